tff_bank: RTL and testbench
===========================

// Module: tff_bank
// PURPOSE
//  - Parametrised bank of WIDTH clocked T flip-flops, the successor to the single-bit T flip-flop.
//  - Adds synchronous reset, a global enable, parallel load, and a ripple-free synchronous COUNT mode.
//  - Used as a general toggle/state register and as a small binary counter/divider.
// PARAMETERS
//  - WIDTH    8   number of flip-flops (channels), >=2
//  - CNT_W    16  width of toggle_cnt (optional feature only)
//  - RST_VAL  0   value of q after reset (WIDTH bits)
// PORTS
//  - clk         in   1      clock, all state updates on rising edge
//  - rst         in   1      synchronous reset, active-high
//  - en          in   1      global enable; 0 = hold all state
//  - mode        in   2      00 HOLD, 01 TOGGLE, 10 LOAD, 11 COUNT
//  - t           in   WIDTH  per-channel toggle inputs (TOGGLE); t[0] is count enable (COUNT)
//  - d           in   WIDTH  parallel load data (LOAD)
//  - q           out  WIDTH  registered flip-flop outputs
//  - qb          out  WIDTH  ~q, combinational from q
//  - wrap        out  1      registered 1-cycle pulse on COUNT rollover
//  - toggle_cnt  out  CNT_W  count of cycles in which q changed (optional)
// BEHAVIOUR
//  - Reset
//    - rst=1 at a rising edge: q<=RST_VAL, wrap<=0, toggle_cnt<=0.
//    - rst has priority over en and mode, including mid-count.
//  - en=0: q holds and wrap<=0, whatever mode, t and d are.
//  - en=1, by mode:
//    - HOLD: q unchanged, wrap<=0.
//    - TOGGLE: q <= q ^ t; every channel is an independent T flip-flop. wrap<=0.
//    - LOAD: q <= d, one-cycle latency. wrap<=0.
//    - COUNT, t[0]=1:
//      - q <= q+1 mod 2^WIDTH.
//      - Built as T chain: bit i toggles iff &q[i-1:0]; bit 0 always toggles.
//    - COUNT, t[0]=0: q holds. t[WIDTH-1:1] are ignored in COUNT.
//  - wrap
//    - Set to 1 on the edge where COUNT takes q from all-ones to all-zeros, so it is high in the same cycle q reads 0.
//    - 0 on every other edge.
//  - Mode changes take effect at the next edge; no pipeline and no hidden state besides q/wrap/toggle_cnt.
//  - qb is always exactly ~q, including during reset.
//  - Latency from any input to q: 1 clock.
// CONFIGURATION
//  - Macro TFF_BANK_TOGGLE_CNT_EN.
//  - Defined:
//    - toggle_cnt increments on every edge where next q != current q (rst=0).
//    - Saturates at 2^CNT_W-1; cleared only by rst.
//  - Undefined:
//    - toggle_cnt is tied to 0 and no counter logic is built.
//    - All other behaviour is identical.
// TESTING (WIDTH=8, RST_VAL=0)
//  - Reset: rst=1 for 2 edges, mode=TOGGLE, t=8'hFF, en=1 -> q=8'h00, qb=8'hFF, wrap=0.
//  - Toggle: en=1, mode=TOGGLE, t=8'hA5 for 2 edges -> q=8'hA5, then 8'h00; t=8'h00 -> q holds.
//  - Load/enable: LOAD d=8'h3C for 1 edge -> q=8'h3C; then en=0, mode=TOGGLE, t=8'hFF for 3 edges -> q stays 8'h3C.
//  - Count/wrap: LOAD 8'hFE; COUNT, t[0]=1 for 3 edges -> q=FF, 00, 01; wrap=1 only in the cycle q=00; t[0]=0 -> q holds.
//  - Reset mid-count: COUNT running, rst=1 at q=8'h7F -> next edge q=00, wrap=0, toggle_cnt=0; counting resumes at 01 after rst drops.
//  - Macro: TOGGLE t=8'h01 for 5 edges, then t=8'h00 for 3 edges -> toggle_cnt=5 with macro, 0 without.

Source files
------------

// File: rtl/tff_bank.sv
// Bank of WIDTH T flip-flops with hold/toggle/load/synchronous-count modes.
// Optional toggle activity counter is built only when TFF_BANK_TOGGLE_CNT_EN is defined.
module tff_bank #(
  parameter int unsigned       WIDTH   = 8,
  parameter int unsigned       CNT_W   = 16,
  parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             wrap,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_LOAD   = 2'b10;
  localparam logic [1:0] MODE_COUNT  = 2'b11;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next_s;
  logic             wrap_r;
  logic             wrap_next_s;
  logic [WIDTH-1:0] cnt_tmask_s;

  // Counting as a T chain: bit i flips only when every lower bit is already one.
  assign cnt_tmask_s[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_tchain
    assign cnt_tmask_s[i] = &q_r[i-1:0];
  end

  // Next-state and wrap decode for all modes.
  always_comb begin
    q_next_s    = q_r;
    wrap_next_s = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD:   q_next_s = q_r;
        MODE_TOGGLE: q_next_s = q_r ^ t;
        MODE_LOAD:   q_next_s = d;
        MODE_COUNT: begin
          if (t[0]) begin
            q_next_s    = q_r ^ cnt_tmask_s;
            wrap_next_s = &q_r;
          end else begin
            q_next_s    = q_r;
          end
        end
        default:     q_next_s = q_r;
      endcase
    end else begin
      q_next_s = q_r;
    end
  end

  // State register; reset overrides enable and mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r    <= RST_VAL;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_next_s;
      wrap_r <= wrap_next_s;
    end
  end

  assign q    = q_r;
  assign qb   = ~q_r;
  assign wrap = wrap_r;

`ifdef TFF_BANK_TOGGLE_CNT_EN
  logic [CNT_W-1:0] toggle_cnt_r;

  // Saturating count of edges where q actually changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_cnt_r <= {CNT_W{1'b0}};
    end else if ((q_next_s != q_r) && (toggle_cnt_r != {CNT_W{1'b1}})) begin
      toggle_cnt_r <= toggle_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      toggle_cnt_r <= toggle_cnt_r;
    end
  end

  assign toggle_cnt = toggle_cnt_r;
`else
  assign toggle_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_tff_bank.sv
// Self-checking bench for tff_bank: directed vector table, corner sequences and a
// random run, all checked through an expected-value scoreboard queue.
module tb_tff_bank;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;
`ifdef TFF_BANK_TOGGLE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  localparam logic [1:0] HOLD = 2'b00, TOG = 2'b01, LOAD = 2'b10, CNT = 2'b11;

  logic             clk = 1'b0;
  logic             rst, en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] t, d, q, qb;
  logic             wrap;
  logic [CNT_W-1:0] toggle_cnt;

  tff_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .d(d),
    .q(q), .qb(qb), .wrap(wrap), .toggle_cnt(toggle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] t;
    logic [7:0] d;
    logic [7:0] q;
    logic       wrap;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic       wrap;
    logic [3:0] cnt;
  } exp_t;

  vec_t       vecs[$];
  exp_t       sb[$];
  int         tests  = 0;
  int         failed = 0;
  logic [7:0] m_q    = 8'h00;
  logic [3:0] m_cnt  = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, push the expectation, then compare after the edge.
  task automatic step(input string name, input logic r, input logic e, input logic [1:0] m,
                      input logic [7:0] tv, input logic [7:0] dv,
                      input logic [7:0] eq, input logic ew);
    exp_t ex;
    @(negedge clk);
    rst = r; en = e; mode = m; t = tv; d = dv;
    if (r) m_cnt = 4'h0;
    else if ((eq != m_q) && (m_cnt != 4'hF)) m_cnt = m_cnt + 4'h1;
    m_q = eq;
    sb.push_back('{q: eq, wrap: ew, cnt: (CNT_ON ? m_cnt : 4'h0)});
    @(posedge clk);
    #1;
    ex = sb.pop_front();
    chk({name, ".q"},    {24'h0, q},          {24'h0, ex.q});
    chk({name, ".qb"},   {24'h0, qb},         {24'h0, ~ex.q});
    chk({name, ".wrap"}, {31'h0, wrap},       {31'h0, ex.wrap});
    chk({name, ".cnt"},  {28'h0, toggle_cnt}, {28'h0, ex.cnt});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       r, e, w;
    logic [1:0] m;
    logic [7:0] tv, dv, nq;

    rst = 1'b1; en = 1'b1; mode = TOG; t = 8'hFF; d = 8'h00;

    //            rst   en    mode  t      d      q      wrap
    vecs.push_back('{1'b1, 1'b1, TOG,  8'hFF, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 1'b1, TOG,  8'hFF, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 1'b1, TOG,  8'hA5, 8'h00, 8'hA5, 1'b0});
    vecs.push_back('{1'b0, 1'b1, TOG,  8'hA5, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 1'b1, TOG,  8'h00, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 1'b1, LOAD, 8'h00, 8'h3C, 8'h3C, 1'b0});
    vecs.push_back('{1'b0, 1'b0, TOG,  8'hFF, 8'h00, 8'h3C, 1'b0});
    vecs.push_back('{1'b0, 1'b0, TOG,  8'hFF, 8'h00, 8'h3C, 1'b0});
    vecs.push_back('{1'b0, 1'b0, TOG,  8'hFF, 8'h00, 8'h3C, 1'b0});
    vecs.push_back('{1'b0, 1'b1, HOLD, 8'hFF, 8'h00, 8'h3C, 1'b0});
    vecs.push_back('{1'b0, 1'b1, LOAD, 8'h00, 8'hFE, 8'hFE, 1'b0});
    vecs.push_back('{1'b0, 1'b1, CNT,  8'h01, 8'h00, 8'hFF, 1'b0});
    vecs.push_back('{1'b0, 1'b1, CNT,  8'h01, 8'h00, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 1'b1, CNT,  8'h01, 8'h00, 8'h01, 1'b0});
    vecs.push_back('{1'b0, 1'b1, CNT,  8'hFE, 8'h00, 8'h01, 1'b0});
    vecs.push_back('{1'b0, 1'b0, CNT,  8'h01, 8'h00, 8'h01, 1'b0});
    vecs.push_back('{1'b0, 1'b1, LOAD, 8'h00, 8'h0F, 8'h0F, 1'b0});
    vecs.push_back('{1'b0, 1'b1, CNT,  8'h01, 8'h00, 8'h10, 1'b0});

    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].en, vecs[i].mode,
           vecs[i].t, vecs[i].d, vecs[i].q, vecs[i].wrap);

    // Reset in the middle of a count, then counting resumes from zero.
    step("midrst.load", 1'b0, 1'b1, LOAD, 8'h00, 8'h7E, 8'h7E, 1'b0);
    step("midrst.c7f",  1'b0, 1'b1, CNT,  8'h01, 8'h00, 8'h7F, 1'b0);
    step("midrst.rst",  1'b1, 1'b1, CNT,  8'h01, 8'h00, 8'h00, 1'b0);
    step("midrst.c01",  1'b0, 1'b1, CNT,  8'h01, 8'h00, 8'h01, 1'b0);
    step("midrst.c02",  1'b0, 1'b1, CNT,  8'h01, 8'h00, 8'h02, 1'b0);

    // Wrap pulse lasts a single cycle even with enable dropped; reset beats a wrapping count.
    step("wrap.load",  1'b0, 1'b1, LOAD, 8'h00, 8'hFF, 8'hFF, 1'b0);
    step("wrap.roll",  1'b0, 1'b1, CNT,  8'h01, 8'h00, 8'h00, 1'b1);
    step("wrap.en0",   1'b0, 1'b0, CNT,  8'h01, 8'h00, 8'h00, 1'b0);
    step("wrap.load2", 1'b0, 1'b1, LOAD, 8'h00, 8'hFF, 8'hFF, 1'b0);
    step("wrap.rst",   1'b1, 1'b1, CNT,  8'h01, 8'h00, 8'h00, 1'b0);

    // Toggle activity counter: five changes, then three idle edges.
    step("tc.rst", 1'b1, 1'b1, HOLD, 8'h00, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++)
      step($sformatf("tc.tog%0d", i), 1'b0, 1'b1, TOG, 8'h01, 8'h00, (i % 2 == 0) ? 8'h01 : 8'h00, 1'b0);
    for (int i = 0; i < 3; i++)
      step($sformatf("tc.idle%0d", i), 1'b0, 1'b1, TOG, 8'h00, 8'h00, 8'h01, 1'b0);
    chk("tc.total", {28'h0, toggle_cnt}, CNT_ON ? 32'd5 : 32'd0);

    // Saturation of the 4-bit activity counter.
    for (int i = 0; i < 12; i++)
      step($sformatf("tc.sat%0d", i), 1'b0, 1'b1, TOG, 8'h80, 8'h00, (i % 2 == 0) ? 8'h81 : 8'h01, 1'b0);
    chk("tc.saturated", {28'h0, toggle_cnt}, CNT_ON ? 32'd15 : 32'd0);

    // Random mix checked against an arithmetic reference model.
    for (int i = 0; i < 80; i++) begin
      r  = ($urandom_range(0, 19) == 0);
      e  = ($urandom_range(0, 5) != 0);
      m  = 2'($urandom_range(0, 3));
      tv = 8'($urandom_range(0, 255));
      dv = (i % 7 == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      nq = m_q;
      w  = 1'b0;
      if (r) begin
        nq = 8'h00;
      end else if (e) begin
        case (m)
          TOG:     nq = m_q ^ tv;
          LOAD:    nq = dv;
          CNT:     if (tv[0]) begin nq = m_q + 8'h01; w = (m_q == 8'hFF); end
          default: nq = m_q;
        endcase
      end
      step($sformatf("rnd%0d", i), r, e, m, tv, dv, nq, w);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
